// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU word and RAM status types
// Provides word_t (32-bit bus word) and ramstate_t (RAM handshake status)
// for the memory arbiter and anything else that talks to the RAM port.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache-side and RAM-side bus bundle for mem_arbiter
// Signals:
//   icache side : iREN, iaddr (in to arbiter), iload, iwait (out)
//   dcache side : dREN, dWEN, daddr, dstore (in), dload, dwait (out)
//   RAM side    : ramREN, ramWEN, ramaddr, ramstore (out), ramload, ramstate (in)
//   status      : err_sticky (out)
// Modports: slave = the arbiter's view, master = the caches plus RAM driving it.
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    word_t     iload;
    logic      iwait;

    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    word_t     dload;
    logic      dwait;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    logic      err_sticky;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore,
               err_sticky
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore,
               err_sticky
    );

endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter between instruction and data caches
// Ports:
//   CLK  : system clock, rising edge
//   nRST : asynchronous active-low reset
//   bus  : mem_arbiter_if.slave (cache requests/responses, RAM strobes/status)
// Parameter:
//   STARVE_MAX : consecutive data grants tolerated while an instruction fetch waits
// Data writes win over data reads, which win over instruction fetches, except
// that a fetch is forced through once STARVE_MAX data grants have been made in a
// row while it was pending. Every access ends with a one-cycle DONE state in
// which the owner's wait line is low, and no grant is made from DONE.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IFETCH = 3'd1,
        DLOAD  = 3'd2,
        DSTORE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] starve_cnt;
    word_t         addr_r;
    word_t         store_r;
    word_t         iload_r;
    word_t         dload_r;
    logic          iwait_r;
    logic          dwait_r;
    logic          ramREN_r;
    logic          ramWEN_r;
    logic          err_r;
    logic          owner_req;
    logic          active;

    // The request that keeps the current access alive; dropping it aborts.
    always_comb begin
        owner_req = 1'b0;
        case (state)
            IFETCH:  owner_req = bus.iREN;
            DLOAD:   owner_req = bus.dREN;
            DSTORE:  owner_req = bus.dWEN;
            default: owner_req = 1'b0;
        endcase
    end

    assign active = (state == IFETCH) || (state == DLOAD) || (state == DSTORE);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            addr_r     <= '0;
            store_r    <= '0;
            iload_r    <= '0;
            dload_r    <= '0;
            iwait_r    <= 1'b1;
            dwait_r    <= 1'b1;
            ramREN_r   <= 1'b0;
            ramWEN_r   <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            // ERROR is recorded whenever the RAM reports it during an access.
            if (active && bus.ramstate == ERROR) begin
                err_r <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.iREN && starve_cnt == SMAX) begin
                        state      <= IFETCH;
                        addr_r     <= bus.iaddr;
                        ramREN_r   <= 1'b1;
                        starve_cnt <= '0;
                    end else if (bus.dWEN) begin
                        state    <= DSTORE;
                        addr_r   <= bus.daddr;
                        store_r  <= bus.dstore;
                        ramWEN_r <= 1'b1;
                        if (bus.iREN) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end else if (bus.dREN) begin
                        state    <= DLOAD;
                        addr_r   <= bus.daddr;
                        ramREN_r <= 1'b1;
                        if (bus.iREN) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end else if (bus.iREN) begin
                        state      <= IFETCH;
                        addr_r     <= bus.iaddr;
                        ramREN_r   <= 1'b1;
                        starve_cnt <= '0;
                    end
                end

                IFETCH, DLOAD, DSTORE: begin
                    if (!owner_req) begin
                        // Abort: silent return, starve_cnt untouched.
                        state    <= IDLE;
                        ramREN_r <= 1'b0;
                        ramWEN_r <= 1'b0;
                    end else if (bus.ramstate == ACCESS) begin
                        state    <= DONE;
                        ramREN_r <= 1'b0;
                        ramWEN_r <= 1'b0;
                        if (state == IFETCH) begin
                            iload_r <= bus.ramload;
                            iwait_r <= 1'b0;
                        end else begin
                            if (state == DLOAD) begin
                                dload_r <= bus.ramload;
                            end
                            dwait_r <= 1'b0;
                        end
                    end
                    // FREE, BUSY and ERROR hold the state and retry.
                end

                DONE: begin
                    state   <= IDLE;
                    iwait_r <= 1'b1;
                    dwait_r <= 1'b1;
                end

                default: begin
                    state    <= IDLE;
                    ramREN_r <= 1'b0;
                    ramWEN_r <= 1'b0;
                    iwait_r  <= 1'b1;
                    dwait_r  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.iload      = iload_r;
    assign bus.dload      = dload_r;
    assign bus.iwait      = iwait_r;
    assign bus.dwait      = dwait_r;
    assign bus.ramREN     = ramREN_r;
    assign bus.ramWEN     = ramWEN_r;
    assign bus.ramaddr    = addr_r;
    assign bus.ramstore   = store_r;
    assign bus.err_sticky = err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int STARVE_MAX = 4;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs;
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = '0;
        bus.ramstate = FREE;
    endtask

    task automatic do_reset;
        idle_inputs();
        nRST = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_iwait"},  bus.iwait, 1);
        chk({tag, "_dwait"},  bus.dwait, 1);
        chk({tag, "_ramREN"}, bus.ramREN, 0);
        chk({tag, "_ramWEN"}, bus.ramWEN, 0);
        chk({tag, "_ramaddr"}, bus.ramaddr, 0);
        chk({tag, "_ramstore"}, bus.ramstore, 0);
        chk({tag, "_err"},    bus.err_sticky, 0);
        chk({tag, "_iload"},  bus.iload, 0);
        chk({tag, "_dload"},  bus.dload, 0);
    endtask

    // Random-phase state: reference memory and RAM contents, cache requests.
    word_t ram_mem [16];
    word_t ref_mem [16];
    int    cnt_model;
    bit    i_pend, d_pend, d_wr;
    word_t i_a, d_a, d_s;
    bit    pi, pdw, pdr, prev_active, active, any_err;
    bit    last_iwait, last_dwait;
    int    own, e_own, obs_own, i_age, d_age, n_icomp, n_dcomp, rr;
    int    got_seq[$];
    int    exp_seq [7];
    int    d_left;
    int    wen_cycles;

    initial begin
        nRST = 1'b0;
        idle_inputs();

        // Reset values.
        tick();
        chk_reset_outputs("reset");
        nRST = 1'b1;
        tick();

        // Single read, ACCESS on the first strobe cycle.
        do_reset();
        bus.dREN  = 1'b1;
        bus.daddr = 32'h100;
        tick();
        chk("rd_ramREN", bus.ramREN, 1);
        chk("rd_ramaddr", bus.ramaddr, 32'h100);
        chk("rd_dwait_busy", bus.dwait, 1);
        bus.ramstate = ACCESS;
        bus.ramload  = 32'hDEADBEEF;
        tick();
        chk("rd_dwait_low", bus.dwait, 0);
        chk("rd_dload", bus.dload, 32'hDEADBEEF);
        chk("rd_iwait", bus.iwait, 1);
        chk("rd_ramREN_done", bus.ramREN, 0);
        bus.dREN     = 1'b0;
        bus.ramstate = FREE;
        bus.ramload  = 32'h0;
        tick();
        chk("rd_dwait_back", bus.dwait, 1);
        chk("rd_dload_hold", bus.dload, 32'hDEADBEEF);

        // Write with three BUSY cycles.
        do_reset();
        bus.dWEN   = 1'b1;
        bus.daddr  = 32'h200;
        bus.dstore = 32'h12345678;
        wen_cycles = 0;
        tick();
        chk("wr_ramaddr", bus.ramaddr, 32'h200);
        chk("wr_ramstore", bus.ramstore, 32'h12345678);
        for (int k = 0; k < 4; k++) begin
            if (bus.ramWEN) wen_cycles++;
            chk("wr_dwait_hold", bus.dwait, 1);
            bus.ramstate = (k < 3) ? BUSY : ACCESS;
            tick();
        end
        chk("wr_ramWEN_cycles", wen_cycles, 4);
        chk("wr_dwait_low", bus.dwait, 0);
        chk("wr_ramWEN_done", bus.ramWEN, 0);
        bus.dWEN     = 1'b0;
        bus.ramstate = FREE;
        tick();
        chk("wr_dwait_one", bus.dwait, 1);

        // Simultaneous fetch and load: data first, fetch after DONE + IDLE.
        do_reset();
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h300;
        bus.dREN  = 1'b1;
        bus.daddr = 32'h400;
        tick();
        chk("sim_first_addr", bus.ramaddr, 32'h400);
        bus.ramstate = ACCESS;
        bus.ramload  = 32'hAAAA0001;
        tick();
        chk("sim_dwait", bus.dwait, 0);
        chk("sim_iwait_hi", bus.iwait, 1);
        bus.dREN     = 1'b0;
        bus.ramstate = FREE;
        tick();
        chk("sim_idle_gap", bus.ramREN, 0);
        tick();
        chk("sim_ifetch_addr", bus.ramaddr, 32'h300);
        chk("sim_ifetch_ren", bus.ramREN, 1);
        bus.ramstate = ACCESS;
        bus.ramload  = 32'hBBBB0002;
        tick();
        chk("sim_iwait", bus.iwait, 0);
        chk("sim_iload", bus.iload, 32'hBBBB0002);
        chk("sim_dload_hold", bus.dload, 32'hAAAA0001);
        idle_inputs();
        tick();

        // Starvation: fetch held, six data reads requested.
        do_reset();
        exp_seq = '{2, 2, 2, 2, 1, 2, 2};
        got_seq.delete();
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h1040;
        bus.dREN  = 1'b1;
        bus.daddr = 32'h2080;
        d_left    = 6;
        for (int c = 0; c < 100 && got_seq.size() < 7; c++) begin
            tick();
            if (!bus.dwait) begin
                got_seq.push_back(2);
                d_left--;
                if (d_left == 0) bus.dREN = 1'b0;
            end
            if (!bus.iwait) begin
                got_seq.push_back(1);
                bus.iREN = 1'b0;
            end
            bus.ramstate = (bus.ramREN || bus.ramWEN) ? ACCESS : FREE;
        end
        chk("starve_count", got_seq.size(), 7);
        for (int k = 0; k < 7; k++) begin
            chk("starve_seq", (k < got_seq.size()) ? got_seq[k] : -1, exp_seq[k]);
        end
        idle_inputs();
        tick();

        // ERROR on first attempt, then ACCESS.
        do_reset();
        bus.dREN  = 1'b1;
        bus.daddr = 32'h500;
        tick();
        bus.ramstate = ERROR;
        tick();
        chk("err_set", bus.err_sticky, 1);
        chk("err_retry_ren", bus.ramREN, 1);
        chk("err_dwait", bus.dwait, 1);
        bus.ramstate = ACCESS;
        bus.ramload  = 32'hCAFEF00D;
        tick();
        chk("err_dwait_low", bus.dwait, 0);
        chk("err_dload", bus.dload, 32'hCAFEF00D);
        idle_inputs();
        tick();
        tick();
        chk("err_persist", bus.err_sticky, 1);

        // Abort while BUSY, then reset during DSTORE.
        do_reset();
        bus.dREN  = 1'b1;
        bus.daddr = 32'h600;
        tick();
        bus.ramstate = BUSY;
        tick();
        chk("abort_busy_ren", bus.ramREN, 1);
        bus.dREN = 1'b0;
        tick();
        chk("abort_ren_off", bus.ramREN, 0);
        chk("abort_no_pulse", bus.dwait, 1);
        bus.ramstate = FREE;
        tick();
        chk("abort_no_pulse2", bus.dwait, 1);
        bus.dWEN   = 1'b1;
        bus.daddr  = 32'h700;
        bus.dstore = 32'h55AA55AA;
        bus.ramstate = BUSY;
        tick();
        chk("rst_pre_wen", bus.ramWEN, 1);
        nRST = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        idle_inputs();
        tick();
        nRST = 1'b1;
        tick();
        chk("rst_after_dwait", bus.dwait, 1);

        // Randomized traffic against the reference model.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            ram_mem[k] = $urandom;
            ref_mem[k] = ram_mem[k];
        end
        cnt_model = 0;
        i_pend = 0; d_pend = 0; d_wr = 0;
        i_a = 32'h1000; d_a = 32'h2000; d_s = 0;
        pi = 0; pdw = 0; pdr = 0; prev_active = 0; any_err = 0;
        last_iwait = 1; last_dwait = 1;
        own = 0; i_age = 0; d_age = 0; n_icomp = 0; n_dcomp = 0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            active = bus.ramREN || bus.ramWEN;
            if (i_pend) i_age++;
            if (d_pend) d_age++;

            if (active && !prev_active) begin
                if (pi && cnt_model == STARVE_MAX) e_own = 1;
                else if (pdw) e_own = 3;
                else if (pdr) e_own = 2;
                else if (pi) e_own = 1;
                else e_own = 0;
                obs_own = bus.ramWEN ? 3 : ((bus.ramaddr[15:12] == 4'h1) ? 1 : 2);
                chk("rnd_grant_owner", obs_own, e_own);
                chk("rnd_grant_addr", bus.ramaddr, (e_own == 1) ? i_a : d_a);
                if (e_own == 1) cnt_model = 0;
                else if (pi && cnt_model < STARVE_MAX) cnt_model++;
                own = e_own;
            end

            if (!bus.iwait) begin
                chk("rnd_iwait_owner", own, 1);
                chk("rnd_iload", bus.iload, ref_mem[i_a[5:2]]);
                chk("rnd_iwait_width", last_iwait, 1);
                chk("rnd_i_latency", i_age <= 200, 1);
                i_pend = 0;
                n_icomp++;
            end
            if (!bus.dwait) begin
                chk("rnd_dwait_owner", own, d_wr ? 3 : 2);
                chk("rnd_dwait_width", last_dwait, 1);
                chk("rnd_d_latency", d_age <= 200, 1);
                if (d_wr) ref_mem[d_a[5:2]] = d_s;
                else chk("rnd_dload", bus.dload, ref_mem[d_a[5:2]]);
                d_pend = 0;
                n_dcomp++;
            end

            if (active) begin
                rr = $urandom_range(0, 99);
                bus.ramstate = (rr < 40) ? ACCESS : (rr < 70) ? BUSY : (rr < 85) ? FREE : ERROR;
                if (bus.ramstate == ERROR) any_err = 1;
                if (bus.ramstate == ACCESS && bus.ramWEN) begin
                    chk("rnd_ramstore", bus.ramstore, d_s);
                    ram_mem[bus.ramaddr[5:2]] = bus.ramstore;
                    bus.ramload = $urandom;
                end else if (bus.ramstate == ACCESS) begin
                    bus.ramload = ram_mem[bus.ramaddr[5:2]];
                end else begin
                    bus.ramload = $urandom;
                end
            end else begin
                bus.ramstate = FREE;
                bus.ramload  = $urandom;
            end

            if (!i_pend && $urandom_range(0, 1) == 1) begin
                i_pend = 1;
                i_a    = 32'h1000 | (32'($urandom_range(0, 15)) << 2);
                i_age  = 0;
            end
            if (!d_pend && $urandom_range(0, 1) == 1) begin
                d_pend = 1;
                d_wr   = ($urandom_range(0, 99) < 40);
                d_a    = 32'h2000 | (32'($urandom_range(0, 15)) << 2);
                d_s    = $urandom;
                d_age  = 0;
            end
            bus.iREN   = i_pend;
            bus.iaddr  = i_a;
            bus.dWEN   = d_pend && d_wr;
            bus.dREN   = d_pend && (!d_wr || ($urandom_range(0, 1) == 1));
            bus.daddr  = d_a;
            bus.dstore = d_s;

            pi          = bus.iREN;
            pdw         = bus.dWEN;
            pdr         = bus.dREN;
            prev_active = active;
            last_iwait  = bus.iwait;
            last_dwait  = bus.dwait;
        end
        chk("rnd_icomp_seen", n_icomp > 50, 1);
        chk("rnd_dcomp_seen", n_dcomp > 50, 1);
        chk("rnd_err_sticky", bus.err_sticky, any_err);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
